// File: rtl/wb_pkg.sv
// Purpose : shared types and width helpers for the write-back / retire stage.
// Latency : n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: wb_entry_t, the retire-buffer entry, sized to the widest supported
//           configuration (XLEN <= 64, NREG <= 256). Users zero-extend on store
//           and read back only the low XLEN/AW/NB bits.
package wb_pkg;

    localparam int WB_XLEN_MAX = 64;
    localparam int WB_AW_MAX   = 8;
    localparam int WB_NB_MAX   = WB_XLEN_MAX / 8;

    typedef struct packed {
        logic [31:0]            pc;
        logic                   gr_we;
        logic [WB_AW_MAX-1:0]   dest;
        logic [WB_XLEN_MAX-1:0] result;
        logic [WB_NB_MAX-1:0]   byte_we;
        logic                   ex;
    } wb_entry_t;

    function automatic int calc_aw(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    function automatic int calc_nb(input int xlen);
        return xlen / 8;
    endfunction

    // Buffer pointer width; at least one bit even for a single-entry buffer.
    function automatic int calc_pw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wb_fwd_lookup.sv
// Purpose : newest-first match of a decode source register against retire-buffer entries.
// Latency : combinational.
// Backpressure: none; o_stall tells decode a partial (byte-masked) write is pending.
// Ports   : i_vld/i_ent  buffer entries ordered newest (index 0) to oldest
//           i_rs         register being looked up
//           o_hit/o_data full-width forwardable value; o_stall partial-write hazard
module wb_fwd_lookup
    import wb_pkg::*;
#(
    parameter int  XLEN  = 32,
    parameter int  NREG  = 32,
    parameter int  DEPTH = 2,
    localparam int AW    = calc_aw(NREG),
    localparam int NB    = calc_nb(XLEN)
) (
    input  logic [DEPTH-1:0] i_vld,
    input  wb_entry_t        i_ent [DEPTH],
    input  logic [AW-1:0]    i_rs,
    output logic             o_hit,
    output logic             o_stall,
    output logic [XLEN-1:0]  o_data
);

    logic w_found;
    logic w_unused_ent;

    // The first matching entry (youngest) decides; older matches are shadowed
    // even if they are full-width, because the younger write wins architecturally.
    always_comb begin
        o_hit   = 1'b0;
        o_stall = 1'b0;
        o_data  = '0;
        w_found = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!w_found && i_vld[k] && i_ent[k].gr_we && !i_ent[k].ex &&
                (i_ent[k].dest[AW-1:0] == i_rs) && (i_rs != '0)) begin
                w_found = 1'b1;
                if (&i_ent[k].byte_we[NB-1:0]) begin
                    o_hit  = 1'b1;
                    o_data = i_ent[k].result[XLEN-1:0];
                end else begin
                    o_stall = 1'b1;
                end
            end
        end
    end

    // Upper (always-zero) struct bits and the PC are not needed here.
    always_comb begin
        w_unused_ent = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            w_unused_ent = w_unused_ent ^ (^i_ent[k]);
        end
    end

endmodule

// File: rtl/wb_retire_stage.sv
// Purpose : in-order retire buffer between MA and the register file; byte-enabled
//           RF write, decode forwarding, one-cycle flush on a retiring exception.
// Latency : entry accepted at edge N drives rf_we in cycle N+1; 1 retire/cycle.
// Backpressure: wb_allowin low when full and not retiring; with WB_TRACE_EN defined,
//           trace_ready stalls retirement and debug_wb_* mirror retirements,
//           otherwise trace_ready is ignored and debug_wb_* are 0.
// Ports   : ma_*  incoming instruction   rf_*  register-file write
//           id_rs/fwd_*  decode lookup   debug_wb_*/trace_ready  trace port
module wb_retire_stage
    import wb_pkg::*;
#(
    parameter int  XLEN  = 32,
    parameter int  NREG  = 32,
    parameter int  DEPTH = 2,
    localparam int AW    = calc_aw(NREG),
    localparam int NB    = calc_nb(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ma_valid,
    output logic            wb_allowin,
    input  logic [31:0]     ma_pc,
    input  logic            ma_gr_we,
    input  logic [AW-1:0]   ma_dest,
    input  logic [XLEN-1:0] ma_result,
    input  logic [NB-1:0]   ma_byte_we,
    input  logic            ma_ex,
    output logic [NB-1:0]   rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            wb_flush,
    input  logic [AW-1:0]   id_rs,
    output logic            fwd_hit,
    output logic            fwd_stall,
    output logic [XLEN-1:0] fwd_data,
    input  logic            trace_ready,
    output logic [31:0]     debug_wb_pc,
    output logic [NB-1:0]   debug_wb_rf_we,
    output logic [AW-1:0]   debug_wb_rf_wnum,
    output logic [XLEN-1:0] debug_wb_rf_wdata
);

    localparam int PW = calc_pw(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t        r_buf [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    wb_entry_t        w_head;
    wb_entry_t        w_new;
    wb_entry_t        w_ord [DEPTH];
    logic [DEPTH-1:0] w_ord_vld;
    logic             w_can_retire;
    logic             w_retire;
    logic             w_accept;
    logic             w_flush;
    logic             w_wr_ok;
    logic             w_unused_head;

    // Wrap explicitly so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef WB_TRACE_EN
    assign w_can_retire = trace_ready;
`else
    assign w_can_retire = 1'b1;
`endif

    assign w_head   = r_buf[r_head];
    // rst gates retirement so nothing is written during a reset cycle.
    assign w_retire = ~rst & (r_count != '0) & w_can_retire;
    assign w_flush  = w_retire & w_head.ex;

    assign wb_allowin = ~rst & ((r_count < CW'(DEPTH)) | w_retire);
    assign w_accept   = ma_valid & wb_allowin;

    assign w_wr_ok  = w_head.gr_we & ~w_head.ex & (w_head.dest[AW-1:0] != '0);
    assign rf_we    = w_retire ? (w_head.byte_we[NB-1:0] & {NB{w_wr_ok}}) : '0;
    assign rf_waddr = w_head.dest[AW-1:0];
    assign rf_wdata = w_head.result[XLEN-1:0];
    assign wb_flush = w_flush;

    assign w_unused_head = ^w_head;

    always_comb begin
        w_new         = '0;
        w_new.pc      = ma_pc;
        w_new.gr_we   = ma_gr_we;
        w_new.dest    = WB_AW_MAX'(ma_dest);
        w_new.result  = WB_XLEN_MAX'(ma_result);
        w_new.byte_we = WB_NB_MAX'(ma_byte_we);
        w_new.ex      = ma_ex;
    end

    // Present the buffer newest-first: slot k is (tail-1-k) mod DEPTH,
    // valid when fewer than count entries precede it.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_ord[k]     = r_buf[PW'((int'(r_tail) + 2 * DEPTH - 1 - k) % DEPTH)];
            w_ord_vld[k] = ~rst & (CW'(k) < r_count);
        end
    end

    wb_fwd_lookup #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .DEPTH (DEPTH)
    ) u_fwd (
        .i_vld   (w_ord_vld),
        .i_ent   (w_ord),
        .i_rs    (id_rs),
        .o_hit   (fwd_hit),
        .o_stall (fwd_stall),
        .o_data  (fwd_data)
    );

    // A retiring exception empties the buffer and drops any same-cycle accept.
    always_ff @(posedge clk) begin
        if (rst | w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) r_tail <= ptr_inc(r_tail);
            if (w_retire) r_head <= ptr_inc(r_head);
            if (w_accept & ~w_retire)      r_count <= r_count + CW'(1);
            else if (~w_accept & w_retire) r_count <= r_count - CW'(1);
        end
    end

    // Datapath storage; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (~rst & ~w_flush & w_accept) begin
            r_buf[r_tail] <= w_new;
        end
    end

`ifdef WB_TRACE_EN
    assign debug_wb_pc       = w_retire ? w_head.pc : 32'h0;
    assign debug_wb_rf_we    = rf_we;
    assign debug_wb_rf_wnum  = w_retire ? rf_waddr : '0;
    assign debug_wb_rf_wdata = w_retire ? rf_wdata : '0;
`else
    logic w_unused_trace;
    assign w_unused_trace    = trace_ready;
    assign debug_wb_pc       = 32'h0;
    assign debug_wb_rf_we    = '0;
    assign debug_wb_rf_wnum  = '0;
    assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_retire_stage.sv
// Purpose : directed self-checking bench for wb_retire_stage (XLEN=32, NREG=32, DEPTH=2).
// Latency : inputs driven at the falling edge, outputs sampled 1 time unit later.
// Backpressure: trace_ready held high except in trace-enabled scenarios.
module tb_wb_retire_stage;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int NB    = 4;
`ifdef WB_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            ma_valid;
    logic            wb_allowin;
    logic [31:0]     ma_pc;
    logic            ma_gr_we;
    logic [AW-1:0]   ma_dest;
    logic [XLEN-1:0] ma_result;
    logic [NB-1:0]   ma_byte_we;
    logic            ma_ex;
    logic [NB-1:0]   rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            wb_flush;
    logic [AW-1:0]   id_rs;
    logic            fwd_hit;
    logic            fwd_stall;
    logic [XLEN-1:0] fwd_data;
    logic            trace_ready;
    logic [31:0]     debug_wb_pc;
    logic [NB-1:0]   debug_wb_rf_we;
    logic [AW-1:0]   debug_wb_rf_wnum;
    logic [XLEN-1:0] debug_wb_rf_wdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_retire_stage #(.XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .ma_valid          (ma_valid),
        .wb_allowin        (wb_allowin),
        .ma_pc             (ma_pc),
        .ma_gr_we          (ma_gr_we),
        .ma_dest           (ma_dest),
        .ma_result         (ma_result),
        .ma_byte_we        (ma_byte_we),
        .ma_ex             (ma_ex),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .wb_flush          (wb_flush),
        .id_rs             (id_rs),
        .fwd_hit           (fwd_hit),
        .fwd_stall         (fwd_stall),
        .fwd_data          (fwd_data),
        .trace_ready       (trace_ready),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    task automatic present(input logic [31:0] pc, input logic gr_we, input logic [AW-1:0] dest,
                           input logic [XLEN-1:0] result, input logic [NB-1:0] be, input logic ex);
        ma_valid   = 1'b1;
        ma_pc      = pc;
        ma_gr_we   = gr_we;
        ma_dest    = dest;
        ma_result  = result;
        ma_byte_we = be;
        ma_ex      = ex;
    endtask

    task automatic idle();
        ma_valid   = 1'b0;
        ma_pc      = '0;
        ma_gr_we   = 1'b0;
        ma_dest    = '0;
        ma_result  = '0;
        ma_byte_we = '0;
        ma_ex      = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        vectors++; if (wb_allowin !== 1'b0) begin miscompares++; $display("FAIL reset_allowin got %b want 0", wb_allowin); end
        @(negedge clk); #1;
        vectors++; if (rf_we !== 4'h0) begin miscompares++; $display("FAIL reset_rf_we got %h want 0", rf_we); end
        vectors++; if (wb_flush !== 1'b0) begin miscompares++; $display("FAIL reset_flush got %b want 0", wb_flush); end
        vectors++; if ({fwd_hit, fwd_stall} !== 2'b00 || fwd_data !== 32'h0) begin miscompares++; $display("FAIL reset_fwd got %b%b %h want 00 0", fwd_hit, fwd_stall, fwd_data); end
        vectors++; if (debug_wb_pc !== 32'h0 || debug_wb_rf_we !== 4'h0) begin miscompares++; $display("FAIL reset_debug got %h %h want 0 0", debug_wb_pc, debug_wb_rf_we); end
        @(negedge clk); rst = 1'b0; #1;
        vectors++; if (wb_allowin !== 1'b1) begin miscompares++; $display("FAIL reset_release_allowin got %b want 1", wb_allowin); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) present(32'h1c000000 + 32'(4 * i), 1'b1, AW'(i + 1), 32'h100 + 32'(i + 1), 4'hF, 1'b0);
            else idle();
            #1;
            vectors++; if (wb_allowin !== 1'b1) begin miscompares++; $display("FAIL b2b_allowin[%0d] got %b want 1", i, wb_allowin); end
            if (i == 0) begin
                vectors++; if (rf_we !== 4'h0) begin miscompares++; $display("FAIL b2b_first_rf_we got %h want 0", rf_we); end
            end else begin
                vectors++; if (rf_we !== 4'hF) begin miscompares++; $display("FAIL b2b_rf_we[%0d] got %h want f", i, rf_we); end
                vectors++; if (rf_waddr !== AW'(i)) begin miscompares++; $display("FAIL b2b_waddr[%0d] got %0d want %0d", i, rf_waddr, i); end
                vectors++; if (rf_wdata !== 32'h100 + 32'(i)) begin miscompares++; $display("FAIL b2b_wdata[%0d] got %h want %h", i, rf_wdata, 32'h100 + 32'(i)); end
                vectors++; if (debug_wb_pc !== (TRACE ? 32'h1c000000 + 32'(4 * (i - 1)) : 32'h0)) begin miscompares++; $display("FAIL b2b_debug_pc[%0d] got %h", i, debug_wb_pc); end
                vectors++; if (debug_wb_rf_we !== (TRACE ? 4'hF : 4'h0)) begin miscompares++; $display("FAIL b2b_debug_we[%0d] got %h", i, debug_wb_rf_we); end
            end
        end
        @(negedge clk); #1;
        vectors++; if (rf_we !== 4'h0) begin miscompares++; $display("FAIL b2b_drained got %h want 0", rf_we); end
    endtask

`ifdef WB_TRACE_EN
    task automatic test_backpressure();
        @(negedge clk); trace_ready = 1'b0;
        present(32'h1c000000, 1'b1, 5'd1, 32'hA1, 4'hF, 1'b0); #1;
        vectors++; if (wb_allowin !== 1'b1) begin miscompares++; $display("FAIL bp_allowin0 got %b want 1", wb_allowin); end
        @(negedge clk); present(32'h1c000004, 1'b1, 5'd2, 32'hA2, 4'hF, 1'b0); #1;
        vectors++; if (wb_allowin !== 1'b1) begin miscompares++; $display("FAIL bp_allowin1 got %b want 1", wb_allowin); end
        @(negedge clk); present(32'h1c000008, 1'b1, 5'd3, 32'hA3, 4'hF, 1'b0); #1;
        vectors++; if (wb_allowin !== 1'b0) begin miscompares++; $display("FAIL bp_full_allowin got %b want 0", wb_allowin); end
        vectors++; if (rf_we !== 4'h0 || debug_wb_pc !== 32'h0) begin miscompares++; $display("FAIL bp_stalled got %h %h want 0 0", rf_we, debug_wb_pc); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); trace_ready = 1'b1;
            if (i > 0) idle();
            #1;
            if (i < 3) begin
                vectors++; if (rf_we !== 4'hF || debug_wb_pc !== 32'h1c000000 + 32'(4 * i)) begin miscompares++; $display("FAIL bp_retire[%0d] got %h pc %h want f pc %h", i, rf_we, debug_wb_pc, 32'h1c000000 + 32'(4 * i)); end
            end else begin
                vectors++; if (rf_we !== 4'h0 || debug_wb_pc !== 32'h0) begin miscompares++; $display("FAIL bp_drained got %h %h want 0 0", rf_we, debug_wb_pc); end
            end
        end
    endtask
`endif

    task automatic test_exception();
`ifdef WB_TRACE_EN
        @(negedge clk); trace_ready = 1'b0;
        present(32'h1c000100, 1'b1, 5'd6, 32'hAA, 4'hF, 1'b1);
        @(negedge clk); present(32'h1c000104, 1'b1, 5'd7, 32'hBB, 4'hF, 1'b0);
        @(negedge clk); trace_ready = 1'b1;
        present(32'h1c000108, 1'b1, 5'd8, 32'hCC, 4'hF, 1'b0);
`else
        @(negedge clk); present(32'h1c000100, 1'b1, 5'd6, 32'hAA, 4'hF, 1'b1);
        @(negedge clk); present(32'h1c000104, 1'b1, 5'd7, 32'hBB, 4'hF, 1'b0);
`endif
        #1;
        vectors++; if (wb_flush !== 1'b1) begin miscompares++; $display("FAIL ex_flush got %b want 1", wb_flush); end
        vectors++; if (rf_we !== 4'h0) begin miscompares++; $display("FAIL ex_no_write got %h want 0", rf_we); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle(); #1;
            vectors++; if (wb_flush !== 1'b0) begin miscompares++; $display("FAIL ex_flush_after[%0d] got %b want 0", i, wb_flush); end
            vectors++; if (rf_we !== 4'h0) begin miscompares++; $display("FAIL ex_discarded[%0d] got %h want 0", i, rf_we); end
        end
    endtask

    task automatic test_forwarding();
`ifdef WB_TRACE_EN
        @(negedge clk); trace_ready = 1'b0;
        present(32'h1c000200, 1'b1, 5'd5, 32'h11, 4'hF, 1'b0);
        @(negedge clk); present(32'h1c000204, 1'b1, 5'd5, 32'h22, 4'hF, 1'b0);
        @(negedge clk); idle(); id_rs = 5'd5; #1;
        vectors++; if (fwd_hit !== 1'b1 || fwd_stall !== 1'b0 || fwd_data !== 32'h22) begin miscompares++; $display("FAIL fwd_newest got %b %b %h want 1 0 22", fwd_hit, fwd_stall, fwd_data); end
        @(negedge clk); trace_ready = 1'b1;
        @(negedge clk);
`else
        @(negedge clk); present(32'h1c000200, 1'b1, 5'd5, 32'h11, 4'hF, 1'b0);
        @(negedge clk); idle(); id_rs = 5'd5; #1;
        vectors++; if (fwd_hit !== 1'b1 || fwd_stall !== 1'b0 || fwd_data !== 32'h11) begin miscompares++; $display("FAIL fwd_full got %b %b %h want 1 0 11", fwd_hit, fwd_stall, fwd_data); end
`endif
        @(negedge clk); present(32'h1c000208, 1'b1, 5'd5, 32'h33, 4'b0011, 1'b0); id_rs = 5'd0;
        @(negedge clk); idle(); id_rs = 5'd5; #1;
        vectors++; if (fwd_stall !== 1'b1 || fwd_hit !== 1'b0) begin miscompares++; $display("FAIL fwd_partial got hit %b stall %b want 0 1", fwd_hit, fwd_stall); end
        id_rs = 5'd6; #1;
        vectors++; if (fwd_hit !== 1'b0 || fwd_stall !== 1'b0 || fwd_data !== 32'h0) begin miscompares++; $display("FAIL fwd_nomatch got %b %b %h want 0 0 0", fwd_hit, fwd_stall, fwd_data); end
        @(negedge clk); id_rs = 5'd0;
    endtask

    task automatic test_r0();
        @(negedge clk); present(32'h1c000300, 1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b0);
        @(negedge clk); idle(); id_rs = 5'd0; #1;
        vectors++; if (rf_wdata !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL r0_head got %h want ffffffff", rf_wdata); end
        vectors++; if (rf_we !== 4'h0) begin miscompares++; $display("FAIL r0_rf_we got %h want 0", rf_we); end
        vectors++; if (fwd_hit !== 1'b0) begin miscompares++; $display("FAIL r0_fwd_hit got %b want 0", fwd_hit); end
        vectors++; if (wb_flush !== 1'b0) begin miscompares++; $display("FAIL r0_flush got %b want 0", wb_flush); end
    endtask

    task automatic test_rst_mid();
`ifdef WB_TRACE_EN
        @(negedge clk); trace_ready = 1'b0;
        present(32'h1c000400, 1'b1, 5'd8, 32'h88, 4'hF, 1'b0);
        @(negedge clk); present(32'h1c000404, 1'b1, 5'd9, 32'h99, 4'hF, 1'b0);
        @(negedge clk); idle(); trace_ready = 1'b1; rst = 1'b1;
`else
        @(negedge clk); present(32'h1c000400, 1'b1, 5'd8, 32'h88, 4'hF, 1'b0);
        @(negedge clk); present(32'h1c000404, 1'b1, 5'd9, 32'h99, 4'hF, 1'b0); rst = 1'b1;
`endif
        #1;
        vectors++; if (rf_we !== 4'h0) begin miscompares++; $display("FAIL rst_mid_no_write got %h want 0", rf_we); end
        vectors++; if (wb_allowin !== 1'b0) begin miscompares++; $display("FAIL rst_mid_allowin got %b want 0", wb_allowin); end
        @(negedge clk); rst = 1'b0; idle(); #1;
        vectors++; if (rf_we !== 4'h0) begin miscompares++; $display("FAIL rst_mid_empty got %h want 0", rf_we); end
        vectors++; if (wb_allowin !== 1'b1) begin miscompares++; $display("FAIL rst_mid_allowin_after got %b want 1", wb_allowin); end
        @(negedge clk); #1;
        vectors++; if (rf_we !== 4'h0) begin miscompares++; $display("FAIL rst_mid_still_empty got %h want 0", rf_we); end
    endtask

    initial begin
        rst         = 1'b1;
        trace_ready = 1'b1;
        id_rs       = '0;
        idle();
        test_reset();
        test_back_to_back();
`ifdef WB_TRACE_EN
        test_backpressure();
`endif
        test_exception();
        test_forwarding();
        test_r0();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_retire_stage.md
# wb_retire_stage

Parametrised write-back stage for the five-stage CPU pipeline. It accepts results from the memory-access stage into a DEPTH-entry in-order retire buffer and retires at most one instruction per cycle. Each retirement drives a byte-enabled register-file write and an optional debug trace. It also provides youngest-match forwarding to decode and a one-cycle flush pulse when a retiring instruction carries an exception.

## Interface
- XLEN, 32: data width; a multiple of 8; NB = XLEN/8 byte lanes
- NREG, 32: architectural registers; AW = $clog2(NREG)
- DEPTH, 2: retire-buffer entries, ≥1
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- ma_valid  in  1  MA stage presents an instruction
- wb_allowin  out  1  buffer accepts this cycle
- ma_pc  in  32  instruction PC
- ma_gr_we  in  1  writes a GPR
- ma_dest  in  AW  destination register
- ma_result  in  XLEN  write data
- ma_byte_we  in  NB  byte lanes to write
- ma_ex  in  1  instruction raised an exception
- rf_we  out  NB  register-file byte write enables
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  XLEN  register-file write data
- wb_flush  out  1  one-cycle flush pulse to upstream stages
- id_rs  in  AW  decode source register to look up
- fwd_hit  out  1  fwd_data is valid for id_rs
- fwd_stall  out  1  a buffered partial write targets id_rs; decode must stall
- fwd_data  out  XLEN  forwarded value
- trace_ready  in  1  trace consumer accepts a retirement
- debug_wb_pc  out  32  retiring PC
- debug_wb_rf_we  out  NB  equal to rf_we
- debug_wb_rf_wnum  out  AW  equal to rf_waddr
- debug_wb_rf_wdata  out  XLEN  equal to rf_wdata

## Operation
- Buffer: circular FIFO with head/tail pointers of width $clog2(DEPTH) (min 1) and a count of 0..DEPTH; pointers wrap at DEPTH, including non-power-of-2 values.
- Accept: ma_valid & wb_allowin stores the entry at the tail.
- wb_allowin = ~rst & ((count < DEPTH) | retire).
- Retire condition: retire = (count != 0) & can_retire. can_retire = trace_ready with WB_TRACE_EN defined; otherwise it is 1.
- Write on retire: rf_we = byte_we & {NB{gr_we & ~ex & (dest != 0)}}. rf_waddr = dest and rf_wdata = result.
- When no retirement occurs, rf_we = 0 and rf_waddr/rf_wdata hold the head entry's fields.
- Exception: retiring an entry with ex = 1 suppresses its write and asserts wb_flush for that cycle.
  - On that clock edge the buffer empties (count set to 0).
  - Any entry accepted in the same cycle is discarded.
- Forwarding: combinational scan from newest to oldest entry. The first valid entry with gr_we & ~ex & dest == id_rs & dest != 0 decides the result.
  - If its byte_we is all ones: fwd_hit = 1 and fwd_data = result.
  - Otherwise: fwd_stall = 1 and fwd_hit = 0.
  - With no match, fwd_hit = fwd_stall = 0 and fwd_data = 0.
- Simultaneous accept and retire while full is legal; count is unchanged.

## Timing
- Reset values: count = 0, pointers = 0, wb_flush = 0, rf_we = 0, fwd_* = 0, debug outputs = 0; wb_allowin = 0 while rst is high.
- Latency: an entry accepted at edge N can retire in cycle N+1 (rf_we asserted in that cycle, write at edge N+1). With trace_ready held high, throughput is one instruction per cycle.
- rst asserted mid-operation discards all entries at the next edge; no write occurs in the rst cycle.
- wb_flush is never asserted for two consecutive cycles unless another ex entry is accepted after the flush.

## Configuration
- WB_TRACE_EN defined:
  - trace_ready back-pressures retirement.
  - debug_wb_* mirror the retirement and are valid only when a retire occurs; otherwise they are 0.
- Not defined:
  - trace_ready is ignored.
  - debug_wb_* are tied to 0.
  - The buffer drains every cycle.

## Structure
- Shared package wb_pkg holds the entry struct (pc, gr_we, dest, result, byte_we, ex) and the AW/NB derivation helpers.
- One sub-module, wb_fwd_lookup: combinational newest-first match over the buffer contents.

## Test plan
- Back-to-back: 4 writes to r1..r4 with trace_ready = 1. Required response: rf_we = 4'hF in 4 consecutive cycles with latency 1 and wb_allowin held at 1.
- Back-pressure (DEPTH = 2, WB_TRACE_EN): trace_ready = 0 and 3 ma_valid. Required response: wb_allowin = 0 after 2 accepts. trace_ready = 1 then retires them in order, with pc 0x1c000000, 0x1c000004, 0x1c000008.
- Exception: entries A (ex = 1) and B buffered, with C presented as A retires. Required response: wb_flush = 1 for one cycle, no rf_we for A, and B and C never written.
- Forwarding: buffer holds r5 = 0x11 (older) and r5 = 0x22 (newer). id_rs = 5 gives fwd_hit = 1 and fwd_data = 0x22. A newer byte_we = 4'b0011 write to r5 gives fwd_stall = 1 instead.
- r0: gr_we = 1, dest = 0, result = 0xFFFFFFFF. Required response: rf_we = 0 on retire and fwd_hit = 0 for id_rs = 0.
- rst mid-stream with 2 entries buffered. Required response: next cycle count = 0, no writes, wb_allowin = 1 after rst drops.
